dm_bridge: RTL and testbench

- Responder end of the data-memory operation code produced by the instruction decoder.
- Accepts one load/store request from the MEM stage and issues a single word-aligned access on the data bus. It drives byte enables and waits for the bus ack, with a watchdog.
- Returns load data with the byte/half lane extracted and sign- or zero-extended.
- Raises busy so the pipeline can freeze while an access is outstanding.

---
 rtl/dm_bridge.sv | 184 ++++++++++++++++++
 tb/tb_dm_bridge.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_bridge.sv
// Data-memory bridge: turns one MEM-stage load/store into a single word-aligned
// bus access with byte enables, a watchdog, and lane-extracted load data.
module dm_bridge #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  // Ops 5..7 fall into the default (word) arm everywhere below.
  function automatic logic [3:0] calc_be(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      3'd1, 3'd3: calc_be = lo[1] ? 4'b1100 : 4'b0011;
      3'd2, 3'd4: calc_be = 4'b0001 << lo;
      default:    calc_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [31:0] wd);
    case (op)
      3'd1, 3'd3: lane_wdata = {wd[15:0], wd[15:0]};
      3'd2, 3'd4: lane_wdata = {4{wd[7:0]}};
      default:    lane_wdata = wd;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      3'd1, 3'd3: is_misaligned = lo[0];
      3'd2, 3'd4: is_misaligned = 1'b0;
      default:    is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] lo,
                                          input logic [31:0] rd);
    logic [15:0] lane;
    lane = 16'(rd >> {lo, 3'b000});
    case (op)
      3'd1:    extract = {{16{lane[15]}}, lane[15:0]};
      3'd2:    extract = {{24{lane[7]}}, lane[7:0]};
      3'd3:    extract = {16'h0000, lane[15:0]};
      3'd4:    extract = {24'h00_0000, lane[7:0]};
      default: extract = rd;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        wd_q, wd_d;
  logic              we_q, we_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_ready_s, busy_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wd_q    <= 8'd0;
      we_q    <= 1'b0;
      op_q    <= 3'd0;
      lo_q    <= 2'd0;
      addr_q  <= '0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    we_d        = we_q;
    op_d        = op_q;
    lo_d        = lo_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready_s = 1'b0;
    busy_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_ready_s = 1'b1;
          we_d        = req_we;
          op_d        = req_op;
          lo_d        = req_addr[1:0];
          addr_d      = {req_addr[ADDR_W-1:2], 2'b00};
          be_d        = calc_be(req_op, req_addr[1:0]);
          wdata_d     = lane_wdata(req_op, req_wdata);
          wd_d        = 8'd0;
          rdata_d     = 32'd0;
          // Misaligned requests never touch the bus and answer next cycle.
          if (is_misaligned(req_op, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            busy_s  = 1'b1;
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        busy_s = 1'b1;
        // Ack is tested first so a same-cycle ack beats the watchdog.
        if (bus_ack) begin
          state_d = RESP;
          rdata_d = we_q ? 32'd0 : extract(op_q, lo_q, bus_rdata);
        end else if (wd_q == WD_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Combinational handshakes are forced low while reset is held.
  assign req_ready  = req_ready_s & reset;
  assign busy       = busy_s & reset;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = err_q & (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign bus_req    = (state_q == REQ);
  assign bus_we     = we_q & (state_q == REQ);
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_dm_bridge.sv
// Scoreboard bench for dm_bridge: expected responses are queued at request time
// and compared by a monitor whenever resp_valid pulses.
module tb_dm_bridge;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, busy, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   resp_cnt = 0;

  dm_bridge #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every resp_valid pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset && resp_valid) begin
      resp_cnt++;
      if (sb_q.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  task automatic run_op(input string tag, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] bus_rd, input int ack_at,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd, input logic exp_err, input logic mis);
    exp_t e;
    int   n;
    int   req_hi;
    bit   done;
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    #1;
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    chk({tag, "/busy0"}, 32'(busy), 32'(!mis));
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    if (!mis) begin
      chk({tag, "/bus_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
      chk({tag, "/bus_be"}, 32'(bus_be), 32'(exp_be));
      chk({tag, "/bus_wdata"}, bus_wdata, exp_wd);
      chk({tag, "/bus_we"}, 32'(bus_we), 32'(we));
      chk({tag, "/busy_req"}, 32'(busy), 32'd1);
      req_hi = 0;
      done   = 1'b0;
      n      = 1;
      while (!done) begin
        if (bus_req) req_hi++;
        if (n == ack_at) begin
          bus_ack = 1'b1; bus_rdata = bus_rd;
        end
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
        if (resp_valid || n >= TO + 2) done = 1'b1;
        n++;
      end
      chk({tag, "/req_cycles"}, 32'(req_hi), (ack_at > 0) ? 32'(ack_at) : 32'(TO));
    end
    chk({tag, "/resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "/bus_req_resp"}, 32'(bus_req), 32'd0);
    chk({tag, "/busy_resp"}, 32'(busy), 32'd0);
    req_valid = 1'b1;
    #1;
    chk({tag, "/ready_resp"}, 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "/resp_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "/busy"}, 32'(busy), 32'd0);
    chk({tag, "/resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "/resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "/resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "/bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, "/bus_we"}, 32'(bus_we), 32'd0);
    chk({tag, "/bus_addr"}, bus_addr, 32'd0);
    chk({tag, "/bus_be"}, 32'(bus_be), 32'd0);
    chk({tag, "/bus_wdata"}, bus_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int r0;
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("wload",   1'b0, 3'd0, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 3, 4'b1111, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_op("lb",      1'b0, 3'd2, 32'h0000_1003, 32'd0, 32'h80FF_0000, 2, 4'b1000, 32'd0, 32'hFFFF_FF80, 1'b0, 1'b0);
    run_op("lbu",     1'b0, 3'd4, 32'h0000_1003, 32'd0, 32'h80FF_0000, 2, 4'b1000, 32'd0, 32'h0000_0080, 1'b0, 1'b0);
    run_op("lh_hi",   1'b0, 3'd1, 32'h0000_1002, 32'd0, 32'h8001_1234, 1, 4'b1100, 32'd0, 32'hFFFF_8001, 1'b0, 1'b0);
    run_op("lhu_hi",  1'b0, 3'd3, 32'h0000_1002, 32'd0, 32'h8001_1234, 2, 4'b1100, 32'd0, 32'h0000_8001, 1'b0, 1'b0);
    run_op("lh_lo",   1'b0, 3'd1, 32'h0000_1000, 32'd0, 32'h1234_8765, 1, 4'b0011, 32'd0, 32'hFFFF_8765, 1'b0, 1'b0);
    run_op("lbu_b1",  1'b0, 3'd4, 32'h0000_1001, 32'd0, 32'h1122_3344, 1, 4'b0010, 32'd0, 32'h0000_0033, 1'b0, 1'b0);
    run_op("op7",     1'b0, 3'd7, 32'h0000_1008, 32'd0, 32'h1234_5678, 2, 4'b1111, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
    run_op("sh",      1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 4'b1100, 32'hABCD_ABCD, 32'd0, 1'b0, 1'b0);
    run_op("sw",      1'b1, 3'd0, 32'h0000_3000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 4'b1111, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    run_op("sb",      1'b1, 3'd2, 32'h0000_3001, 32'h0000_00A5, 32'hFFFF_FFFF, 4, 4'b0010, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0);
    run_op("mis_w",   1'b0, 3'd0, 32'h0000_1001, 32'd0, 32'd0, 0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b1);
    run_op("mis_h",   1'b0, 3'd1, 32'h0000_1003, 32'd0, 32'd0, 0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b1);
    run_op("mis_sh",  1'b1, 3'd3, 32'h0000_1001, 32'h1111_2222, 32'd0, 0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b1);
    run_op("tmo",     1'b0, 3'd0, 32'h0000_4000, 32'd0, 32'd0, 0, 4'b1111, 32'd0, 32'd0, 1'b1, 1'b0);
    run_op("tmo_ack", 1'b0, 3'd0, 32'h0000_4000, 32'd0, 32'h0BAD_F00D, TO, 4'b1111, 32'd0, 32'h0BAD_F00D, 1'b0, 1'b0);

    r0 = resp_cnt;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    bus_ack = 1'b0;
    chk("idle_ack/bus_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    chk("idle_ack/resp_cnt", 32'(resp_cnt), 32'(r0));

    req_valid = 1'b1; req_we = 1'b1; req_op = 3'd0; req_addr = 32'h0000_5000; req_wdata = 32'h7777_7777;
    sb_q.push_back('{rdata: 32'd0, err: 1'b0});
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid/bus_req_before", 32'(bus_req), 32'd1);
    r0 = resp_cnt;
    req_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    void'(sb_q.pop_back());
    repeat (TO + 4) @(posedge clk);
    #1;
    chk("rst_mid/no_resp", 32'(resp_cnt), 32'(r0));
    chk("rst_mid/bus_req_after", 32'(bus_req), 32'd0);

    run_op("post_rst", 1'b0, 3'd2, 32'h0000_1000, 32'd0, 32'h0000_007F, 2, 4'b0001, 32'd0, 32'h0000_007F, 1'b0, 1'b0);

    @(posedge clk); #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
